// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage owning the PC; req/ready fetch,
//               hold-until-ack, sticky halt on the halt opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_out,
    input  logic [15:0] next_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [15:0] c_align_mask = 16'hFFFE;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_req_pending;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_retired;
    logic        w_req;
    logic        w_capture;
    logic        w_accept;
    logic        w_is_halt;

    assign w_is_halt = (r_instr[15:12] == HALT_OPCODE);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // An issued request is never withdrawn, even if stall rises.
                w_req = r_req_pending | ~stall;
                if (w_req && imem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_accept = instr_ack & ~stall;
                if (w_accept) begin
                    w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_req_pending <= 1'b0;
            r_pc          <= RESET_PC;
            r_instr       <= 16'h0000;
            r_retired     <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_req_pending <= w_req & ~imem_ready;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_retired <= r_retired + 16'd1;
                // The halt instruction leaves the PC at its own address.
                if (!w_is_halt) begin
                    r_pc <= next_pc & c_align_mask;
                end
            end
        end
    end

    // Gating with rst_n drops the request immediately when reset asserts.
    assign imem_req    = w_req & rst_n;
    assign pc_out      = r_pc;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_HOLD);
    assign halted      = (r_state == S_HALT);
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit with an instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_out;
    logic [15:0] next_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        halted;
    logic [15:0] retired;

    logic        np_ovr_en;
    logic [15:0] np_ovr;
    logic [15:0] sb[$];
    int          total;
    int          passed;
    logic [15:0] exp_ret;

    fetch_unit #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_out      (pc_out),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .halted      (halted),
        .retired     (retired)
    );

    // Stand-in for the branch unit: sequential PC+2 unless a target is forced.
    assign next_pc = np_ovr_en ? np_ovr : pc_out + 16'd2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_instr(input string tag);
        logic [15:0] e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, instr);
        end else begin
            e = sb.pop_front();
            chk(tag, instr, e);
        end
    endtask

    // Serve one fetch after wait_cycles of memory latency and check the capture.
    task automatic fetch(input logic [15:0] word, input int wait_cycles);
        for (int w = 0; w < wait_cycles; w++) begin
            chk("req_wait", {15'd0, imem_req}, 16'd1);
            step();
        end
        chk("req_on_ready", {15'd0, imem_req}, 16'd1);
        imem_ready = 1'b1;
        imem_rdata = word;
        sb.push_back(word);
        step();
        imem_ready = 1'b0;
        imem_rdata = 16'h0000;
        chk("hold_valid", {15'd0, instr_valid}, 16'd1);
        chk("hold_req_low", {15'd0, imem_req}, 16'd0);
        chk_instr("captured_instr");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc_out, 16'h0000);
        chk({tag, "_instr"}, instr, 16'h0000);
        chk({tag, "_valid"}, {15'd0, instr_valid}, 16'd0);
        chk({tag, "_req"}, {15'd0, imem_req}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
        chk({tag, "_retired"}, retired, 16'h0000);
    endtask

    initial begin
        total = 0; passed = 0; exp_ret = 16'd0;
        rst_n = 1'b0; stall = 1'b0; instr_ack = 1'b0;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        np_ovr_en = 1'b0; np_ovr = 16'h0000;

        // Reset state, then req rises combinationally on release.
        step(); step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        #1;
        chk("req_after_release", {15'd0, imem_req}, 16'd1);

        // Sequential stream, zero-wait memory, ack tied high: 2 cycles each.
        instr_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 16'(2 * i));
            fetch(16'h1000 | 16'(i), 0);
            step();
            exp_ret++;
            chk("seq_back_to_fetch", {15'd0, instr_valid}, 16'd0);
        end
        chk("seq_retired", retired, 16'd3);
        chk("seq_pc", pc_out, 16'h0006);

        // Odd branch target is word-aligned.
        np_ovr_en = 1'b1; np_ovr = 16'h0041;
        fetch(16'h2222, 0);
        step();
        exp_ret++;
        np_ovr_en = 1'b0;
        chk("branch_addr", imem_addr, 16'h0040);
        fetch(16'h3040, 0);
        step();
        exp_ret++;
        chk("branch_next_pc", pc_out, 16'h0042);
        chk("branch_retired", retired, exp_ret);

        // Stall after issue: request held; ready with stall still captures.
        instr_ack = 1'b0;
        step();
        stall = 1'b1;
        #1;
        fetch(16'h4042, 3);
        instr_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_ack_pc", pc_out, 16'h0042);
            chk("stall_ack_retired", retired, exp_ret);
            chk("stall_ack_valid", {15'd0, instr_valid}, 16'd1);
        end
        stall = 1'b0;
        step();
        exp_ret++;
        chk("unstall_pc", pc_out, 16'h0044);
        chk("unstall_retired", retired, exp_ret);

        // Stall with nothing outstanding blocks the request; stray ready ignored.
        stall = 1'b1;
        #1;
        chk("stall_no_req", {15'd0, imem_req}, 16'd0);
        imem_ready = 1'b1; imem_rdata = 16'hBEEF;
        step();
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        chk("stray_ready_valid", {15'd0, instr_valid}, 16'd0);
        chk("stray_ready_instr", instr, 16'h4042);
        stall = 1'b0;
        #1;

        // Branch to 0x0010, then halt there.
        np_ovr_en = 1'b1; np_ovr = 16'h0010;
        fetch(16'h5044, 0);
        step();
        exp_ret++;
        np_ovr_en = 1'b0;
        chk("halt_addr", imem_addr, 16'h0010);
        fetch(16'hF000, 0);
        step();
        exp_ret++;
        chk("halted", {15'd0, halted}, 16'd1);
        chk("halt_pc", pc_out, 16'h0010);
        chk("halt_retired", retired, exp_ret);
        imem_ready = 1'b1; imem_rdata = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_req", {15'd0, imem_req}, 16'd0);
            chk("halt_valid", {15'd0, instr_valid}, 16'd0);
            chk("halt_frozen_ret", retired, exp_ret);
            chk("halt_frozen_instr", instr, 16'hF000);
            chk("halt_frozen_pc", pc_out, 16'h0010);
        end
        imem_ready = 1'b0; imem_rdata = 16'h0000;

        // Reset out of halt, then reset mid-request.
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_from_halt");
        step();
        rst_n = 1'b1;
        instr_ack = 1'b0;
        exp_ret = 16'd0;
        step();
        chk("mid_req_before", {15'd0, imem_req}, 16'd1);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_mid_req");
        step();
        rst_n = 1'b1;
        #1;
        chk("restart_addr", imem_addr, 16'h0000);

        // Reset while holding an instruction.
        fetch(16'h6000, 1);
        rst_n = 1'b0;
        #2;
        chk_reset_vals("rst_in_hold");
        step();

        // Retired wrap and self-loop branch: preload the counter while idle.
        stall = 1'b1;
        rst_n = 1'b1;
        #1;
        force dut.r_retired = 16'hFFFF;
        step();
        release dut.r_retired;
        step();
        chk("preload_retired", retired, 16'hFFFF);
        stall = 1'b0;
        np_ovr_en = 1'b1; np_ovr = 16'h0000;
        #1;
        instr_ack = 1'b1;
        fetch(16'h7000, 0);
        step();
        chk("wrap_retired", retired, 16'h0000);
        chk("self_loop_addr", imem_addr, 16'h0000);
        chk("self_loop_req", {15'd0, imem_req}, 16'd1);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
